// File: rtl/digit_scan_mux_if.sv
// Display-scan bundle: scan enable, four digit values and dp mask in; slot select and drive out.
// master drives the digit values and enable; slave is the scan driver.
// Widths follow DIGIT_W, which must match the driver's parameter.
interface digit_scan_mux_if #(
  parameter int DIGIT_W = 4
);
  logic               en;
  logic [DIGIT_W-1:0] d0;
  logic [DIGIT_W-1:0] d1;
  logic [DIGIT_W-1:0] d2;
  logic [DIGIT_W-1:0] d3;
  logic [3:0]         dp_mask;
  logic [1:0]         sel;
  logic               active;
  logic [DIGIT_W-1:0] digit;
  logic               dp;
  logic               blank;
  logic               tick;

  modport master (
    output en, d0, d1, d2, d3, dp_mask,
    input  sel, active, digit, dp, blank, tick
  );

  modport slave (
    input  en, d0, d1, d2, d3, dp_mask,
    output sel, active, digit, dp, blank, tick
  );
endinterface

// File: rtl/digit_scan_mux.sv
// Scan driver for a 4-digit display: steps sel every CLK_DIV enabled cycles, muxes digit/dp/blank.
// Latency: all outputs registered; input digit/dp changes appear 1 cycle later, aligned with sel.
// No backpressure: en=0 freezes the scan and drops active. Option macro: LEADING_ZERO_BLANK_EN.
module digit_scan_mux #(
  parameter int CLK_DIV = 1000,
  parameter int DIGIT_W = 4
) (
  input logic clk,
  input logic rst,
  digit_scan_mux_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0]      cnt;
  logic [1:0]         sel;
  logic               active;
  logic [DIGIT_W-1:0] digit;
  logic               dp;
  logic               blank;
  logic               tick;

  logic               wrap;
  logic [1:0]         sel_nxt;
  logic [DIGIT_W-1:0] digit_nxt;
  logic               blank_nxt;

  // Next slot: advance only when the prescaler finishes an enabled slot.
  always_comb begin
    wrap    = bus.en && (cnt == CNT_MAX);
    sel_nxt = wrap ? sel + 2'd1 : sel;
  end

  // Pick the digit for the slot sel is about to hold, so digit/dp/blank never lag sel.
  always_comb begin
    digit_nxt = bus.d0;
    case (sel_nxt)
      2'd0: digit_nxt = bus.d0;
      2'd1: digit_nxt = bus.d1;
      2'd2: digit_nxt = bus.d2;
      2'd3: digit_nxt = bus.d3;
      default: digit_nxt = bus.d0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A position is blank when it and every position to its left hold zero; position 0 always shows.
  always_comb begin
    blank_nxt = 1'b0;
    case (sel_nxt)
      2'd3: blank_nxt = (bus.d3 == '0);
      2'd2: blank_nxt = (bus.d3 == '0) && (bus.d2 == '0);
      2'd1: blank_nxt = (bus.d3 == '0) && (bus.d2 == '0) && (bus.d1 == '0);
      default: blank_nxt = 1'b0;
    endcase
  end
`else
  // Leading-zero suppression not built: nothing is ever blanked.
  always_comb begin
    blank_nxt = 1'b0;
  end
`endif

  // Prescaler, slot select and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sel    <= 2'd0;
      active <= 1'b0;
      digit  <= '0;
      dp     <= 1'b0;
      blank  <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (bus.en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      sel    <= sel_nxt;
      tick   <= wrap;
      active <= bus.en;
      digit  <= digit_nxt;
      dp     <= bus.dp_mask[sel_nxt];
      blank  <= blank_nxt;
    end
  end

  assign bus.sel    = sel;
  assign bus.active = active;
  assign bus.digit  = digit;
  assign bus.dp     = dp;
  assign bus.blank  = blank;
  assign bus.tick   = tick;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux at CLK_DIV=4: directed scenarios with literal expectations,
// then randomized enable/digit/reset traffic checked every cycle against a counting model.
// Blank expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_digit_scan_mux;

  localparam int CLK_DIV = 4;
  localparam int DIGIT_W = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  digit_scan_mux_if #(.DIGIT_W(DIGIT_W)) bus ();

  digit_scan_mux #(.CLK_DIV(CLK_DIV), .DIGIT_W(DIGIT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sel is the number of completed CLK_DIV-long enabled slots mod 4.
  int          en_edges;
  logic        m_valid;
  logic [1:0]  m_sel;
  logic        m_tick;
  logic        m_act;
  logic [3:0]  m_digit;
  logic        m_dp;
  logic        m_blank;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] dv [4];
    logic all_zero;
    dv[0] = bus.d0; dv[1] = bus.d1; dv[2] = bus.d2; dv[3] = bus.d3;
    if (rst) begin
      en_edges = 0;
      m_sel = 0; m_tick = 0; m_act = 0; m_digit = 0; m_dp = 0; m_blank = 0;
      m_valid = 1'b1;
    end else begin
      if (bus.en) en_edges++;
      m_sel   = 2'((en_edges / CLK_DIV) % 4);
      m_tick  = bus.en && (en_edges % CLK_DIV == 0);
      m_act   = bus.en;
      m_digit = dv[m_sel];
      m_dp    = bus.dp_mask[m_sel];
      all_zero = 1'b1;
      for (int j = int'(m_sel); j < 4; j++) if (dv[j] != 0) all_zero = 1'b0;
      m_blank = LZB && (m_sel != 0) && all_zero;
    end
  end

  // Every cycle after the first reset edge, outputs must equal the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_sel",    32'(bus.sel),    32'(m_sel));
      check("m_tick",   32'(bus.tick),   32'(m_tick));
      check("m_active", 32'(bus.active), 32'(m_act));
      check("m_digit",  32'(bus.digit),  32'(m_digit));
      check("m_dp",     32'(bus.dp),     32'(m_dp));
      check("m_blank",  32'(bus.blank),  32'(m_blank));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_digits(input int a3, input int a2, input int a1, input int a0);
    bus.d3 = 4'(a3); bus.d2 = 4'(a2); bus.d1 = 4'(a1); bus.d0 = 4'(a0);
  endtask

  function automatic logic [3:0] rand_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // 1. reset with random inputs
    rst = 1'b1;
    bus.en = 1'($urandom);
    set_digits($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    bus.dp_mask = 4'($urandom);
    step(2);
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_digit", 32'(bus.digit), 0);
    check("rst_dp", 32'(bus.dp), 0);
    check("rst_blank", 32'(bus.blank), 0);
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_active", 32'(bus.active), 0);

    // 2. basic scan
    rst = 1'b0;
    bus.en = 1'b1;
    set_digits(4, 3, 2, 1);
    bus.dp_mask = 4'b0100;
    step(3);
    check("t2_sel_e3", 32'(bus.sel), 0);
    step(1);
    check("t2_sel_e4", 32'(bus.sel), 1);
    check("t2_digit_e4", 32'(bus.digit), 2);
    check("t2_tick_e4", 32'(bus.tick), 1);
    check("t2_dp_e4", 32'(bus.dp), 0);
    step(1);
    check("t2_tick_e5", 32'(bus.tick), 0);
    step(3);
    check("t2_sel_e8", 32'(bus.sel), 2);
    check("t2_digit_e8", 32'(bus.digit), 3);
    check("t2_dp_e8", 32'(bus.dp), 1);
    step(4);
    check("t2_sel_e12", 32'(bus.sel), 3);
    check("t2_digit_e12", 32'(bus.digit), 4);
    check("t2_dp_e12", 32'(bus.dp), 0);
    step(4);
    check("t2_sel_e16", 32'(bus.sel), 0);
    check("t2_digit_e16", 32'(bus.digit), 1);
    check("t2_tick_e16", 32'(bus.tick), 1);

    // 3. pause at sel=1, cnt=2
    step(6);
    bus.en = 1'b0;
    step(1);
    check("t3_active_off", 32'(bus.active), 0);
    check("t3_sel_hold", 32'(bus.sel), 1);
    check("t3_tick_off", 32'(bus.tick), 0);
    step(9);
    check("t3_sel_hold10", 32'(bus.sel), 1);
    bus.en = 1'b1;
    step(1);
    check("t3_sel_resume1", 32'(bus.sel), 1);
    check("t3_active_on", 32'(bus.active), 1);
    step(1);
    check("t3_sel_resume2", 32'(bus.sel), 2);

    // 4. live digit change in slot 2
    bus.d2 = 4'd7;
    step(1);
    check("t4_digit7", 32'(bus.digit), 7);
    bus.d2 = 4'd9;
    step(1);
    check("t4_digit9", 32'(bus.digit), 9);
    check("t4_sel", 32'(bus.sel), 2);

    // 5. mid-scan reset at sel=3, cnt=2
    step(4);
    check("t5_sel_pre", 32'(bus.sel), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_sel", 32'(bus.sel), 0);
    check("t5_digit", 32'(bus.digit), 0);
    check("t5_active", 32'(bus.active), 0);
    check("t5_dp", 32'(bus.dp), 0);
    step(3);
    check("t5_sel_e3", 32'(bus.sel), 0);
    step(1);
    check("t5_sel_e4", 32'(bus.sel), 1);

    // 6. leading-zero blanking
    rst = 1'b1;
    set_digits(0, 0, 5, 0);
    step(1);
    rst = 1'b0;
    step(4);
    check("t6_sel1", 32'(bus.sel), 1);
    check("t6_blank1", 32'(bus.blank), 0);
    step(4);
    check("t6_sel2", 32'(bus.sel), 2);
    check("t6_blank2", 32'(bus.blank), 32'(LZB));
    step(4);
    check("t6_sel3", 32'(bus.sel), 3);
    check("t6_blank3", 32'(bus.blank), 32'(LZB));
    step(4);
    check("t6_sel0", 32'(bus.sel), 0);
    check("t6_blank0", 32'(bus.blank), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.d0 = rand_digit(); bus.d1 = rand_digit();
        bus.d2 = rand_digit(); bus.d3 = rand_digit();
        bus.dp_mask = 4'($urandom);
      end
      step(1);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
